// File: rtl/uart_buf_pkg.sv
// Shared definitions for the UART byte history/replay buffer.
//   state_e      : controller states (idle, pop, hold, send)
//   DefaultWidth : default UART data word width
package uart_buf_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StPop  = 2'd1,
    StHold = 2'd2,
    StSend = 2'd3
  } state_e;

endpackage

// File: rtl/uart_byte_shiftbuf.sv
// UART byte history buffer with replay.
// Pops bytes from a show-ahead UART receive FIFO into a shift history (byte 0 newest) and, on
// send_tick, replays the history to the transmit FIFO oldest byte first.
// Optional feature: define UART_BUF_ECHO_EN to echo every popped byte to the transmit FIFO.
//
// Ports
//   clk       : system clock, rising edge
//   reset     : asynchronous active-high reset
//   rx_empty  : receive FIFO empty
//   r_data    : receive FIFO head (valid while rx_empty=0)
//   rd_uart   : one-cycle pop strobe to the receive FIFO (registered)
//   tx_full   : transmit FIFO full
//   w_data    : byte presented to the transmit FIFO (registered)
//   wr_uart   : one-cycle push strobe to the transmit FIFO (registered)
//   send_tick : single-cycle replay request
//   words     : history, byte 0 (LSBs) newest
//   count     : number of valid history bytes, saturating at NBYTES
//   busy      : controller not idle
module uart_byte_shiftbuf
  import uart_buf_pkg::*;
#(
  parameter int unsigned NBYTES = 2,
  parameter int unsigned WIDTH  = DefaultWidth
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx_empty,
  input  logic [WIDTH-1:0]              r_data,
  output logic                          rd_uart,
  input  logic                          tx_full,
  output logic [WIDTH-1:0]              w_data,
  output logic                          wr_uart,
  input  logic                          send_tick,
  output logic [NBYTES*WIDTH-1:0]       words,
  output logic [$clog2(NBYTES+1)-1:0]   count,
  output logic                          busy
);

  localparam int unsigned CntW = $clog2(NBYTES + 1);
  localparam int unsigned IdxW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  state_e                  state_q;
  logic [NBYTES*WIDTH-1:0] words_q;
  logic [NBYTES*WIDTH-1:0] words_shift;
  logic [CntW-1:0]         count_q;
  logic [IdxW-1:0]         index_q;
  logic                    rd_q;
  logic                    wr_q;
  logic                    busy_q;
  logic [WIDTH-1:0]        wdata_q;
  logic [WIDTH-1:0]        sel_byte;

  // New byte enters at the bottom, oldest byte falls off the top.
  always_comb begin
    words_shift              = words_q << WIDTH;
    words_shift[WIDTH-1:0]   = r_data;
  end

  always_comb begin
    sel_byte = words_q[index_q*WIDTH +: WIDTH];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      words_q <= '0;
      count_q <= '0;
      index_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      wdata_q <= '0;
    end else begin
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // Replay request has priority over a waiting receive byte.
          if (send_tick) begin
            state_q <= StSend;
            index_q <= IdxW'(count_q - CntW'(1));
            busy_q  <= 1'b1;
          end else if (!rx_empty) begin
            state_q <= StPop;
            rd_q    <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        StPop: begin
          // rd_uart is high in this cycle, so the FIFO pops at this edge while r_data is captured.
          words_q <= words_shift;
          if (count_q != CntW'(NBYTES)) begin
            count_q <= count_q + CntW'(1);
          end
          state_q <= StHold;
`ifdef UART_BUF_ECHO_EN
          // Registered so the echo strobe lands in the HOLD cycle; a full FIFO drops the echo.
          if (!tx_full) begin
            wr_q    <= 1'b1;
            wdata_q <= r_data;
          end
`endif
        end
        StHold: begin
          // One idle cycle lets the FIFO empty flag reflect the pop.
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        StSend: begin
          if (count_q == '0) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else if (!tx_full) begin
            wr_q    <= 1'b1;
            wdata_q <= sel_byte;
            index_q <= index_q - IdxW'(1);
            if (index_q == '0) begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rd_uart = rd_q;
  assign wr_uart = wr_q;
  assign w_data  = wdata_q;
  assign words   = words_q;
  assign count   = count_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_uart_byte_shiftbuf.sv
// Self-checking bench for uart_byte_shiftbuf: models the receive FIFO as a queue, logs transmit
// pushes, and compares against a transaction-level history model (last NBYTES received bytes).
module tb_uart_byte_shiftbuf;

  localparam int unsigned NBYTES = 2;
  localparam int unsigned WIDTH  = 8;
  localparam int unsigned CntW   = $clog2(NBYTES + 1);

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    rx_empty;
  logic [WIDTH-1:0]        r_data;
  logic                    rd_uart;
  logic                    tx_full;
  logic [WIDTH-1:0]        w_data;
  logic                    wr_uart;
  logic                    send_tick;
  logic [NBYTES*WIDTH-1:0] words;
  logic [CntW-1:0]         count;
  logic                    busy;

  always #5 clk = ~clk;

  uart_byte_shiftbuf #(
    .NBYTES(NBYTES),
    .WIDTH (WIDTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_empty (rx_empty),
    .r_data   (r_data),
    .rd_uart  (rd_uart),
    .tx_full  (tx_full),
    .w_data   (w_data),
    .wr_uart  (wr_uart),
    .send_tick(send_tick),
    .words    (words),
    .count    (count),
    .busy     (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int busy_cnt = 0;
  logic prev_txf = 1'b0;

  byte unsigned rx_q[$];
  byte unsigned hist[$];
  byte unsigned exp_tx[$];
  byte unsigned tx_got[$];
  int           rd_cycles[$];
  int           wr_cycles[$];

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic refresh_rx();
    rx_empty = (rx_q.size() == 0);
    r_data   = rx_empty ? 8'($urandom) : rx_q[0];
  endtask

  // One clock: observe outputs mid-cycle, then apply the FIFO pop just after the edge.
  task automatic tick();
    bit pop_now = 0;
    @(negedge clk);
    if (rd_uart) begin
      check_eq("rx_underflow", rx_q.size() == 0, 0);
      if (rd_cycles.size() > 0) check_eq("pop_spacing", (cyc - rd_cycles[$]) >= 3, 1);
      rd_cycles.push_back(cyc);
      pop_now = 1;
    end
    if (wr_uart) begin
      check_eq("wr_after_tx_full", prev_txf, 0);
      tx_got.push_back(w_data);
      wr_cycles.push_back(cyc);
    end
    if (busy) busy_cnt++;
    prev_txf = tx_full;
    @(posedge clk);
    #1;
    cyc++;
    if (pop_now && rx_q.size() > 0) void'(rx_q.pop_front());
    refresh_rx();
  endtask

  function automatic logic [NBYTES*WIDTH-1:0] exp_words();
    logic [NBYTES*WIDTH-1:0] w = '0;
    for (int i = 0; i < hist.size(); i++) w[i*WIDTH +: WIDTH] = hist[hist.size()-1-i];
    return w;
  endfunction

  task automatic push_rx(input byte unsigned b);
    rx_q.push_back(b);
    hist.push_back(b);
    if (hist.size() > NBYTES) void'(hist.pop_front());
`ifdef UART_BUF_ECHO_EN
    exp_tx.push_back(b);
`endif
    refresh_rx();
  endtask

  // A replay emits the current history oldest first.
  task automatic queue_send_exp();
    foreach (hist[i]) exp_tx.push_back(hist[i]);
  endtask

  task automatic settle(input string tag);
    int n = 0;
    while ((rx_q.size() != 0 || busy) && n < 200) begin
      tick();
      n++;
    end
    check_eq({tag, "_timeout"}, n < 200, 1);
    tick();
    tick();
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, "_words"}, words, exp_words());
    check_eq({tag, "_count"}, count, hist.size());
  endtask

  task automatic check_tx(input string tag);
    check_eq({tag, "_tx_len"}, tx_got.size(), exp_tx.size());
    for (int i = 0; i < tx_got.size() && i < exp_tx.size(); i++)
      check_eq({tag, "_tx_byte"}, tx_got[i], exp_tx[i]);
    tx_got.delete();
    exp_tx.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr0;
    int rd0;
    int drop;
    reset     = 1'b1;
    send_tick = 1'b0;
    tx_full   = 1'b0;
    refresh_rx();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_rd_uart", rd_uart, 0);
    check_eq("rst_wr_uart", wr_uart, 0);
    check_eq("rst_w_data", w_data, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_words", words, 0);
    check_eq("rst_count", count, 0);
    reset = 1'b0;
    tick();

    // Replay of an empty history: one busy cycle, no writes.
    busy_cnt  = 0;
    send_tick = 1'b1;
    tick();
    send_tick = 1'b0;
    repeat (5) tick();
    check_eq("empty_send_busy_cycles", busy_cnt, 1);
    check_eq("empty_send_writes", tx_got.size(), 0);

    // Fill: three bytes into a two-byte history.
    rd0 = rd_cycles.size();
    push_rx(8'h12);
    push_rx(8'h34);
    push_rx(8'h56);
    settle("fill");
    check_eq("fill_words_const", words, 16'h3456);
    check_eq("fill_count_const", count, 2);
    check_eq("fill_pops", rd_cycles.size() - rd0, 3);
    check_state("fill");
    check_tx("fill");

    // Plain replay.
    wr0 = wr_cycles.size();
    queue_send_exp();
    send_tick = 1'b1;
    tick();
    send_tick = 1'b0;
    settle("send");
    check_eq("send_wr_count", wr_cycles.size() - wr0, 2);
    if (wr_cycles.size() >= wr0 + 2)
      check_eq("send_consecutive", wr_cycles[wr0+1] - wr_cycles[wr0], 1);
    check_eq("send_busy_after", busy, 0);
    check_eq("send_words_kept", words, 16'h3456);
    check_tx("send");

    // Replay stalled by tx_full for five cycles after the first write.
    wr0 = wr_cycles.size();
    queue_send_exp();
    send_tick = 1'b1;
    tick();
    send_tick = 1'b0;
    tick();
    tx_full = 1'b1;
    repeat (5) tick();
    drop    = cyc;
    tx_full = 1'b0;
    settle("stall");
    check_eq("stall_wr_count", wr_cycles.size() - wr0, 2);
    if (wr_cycles.size() >= wr0 + 2) begin
      check_eq("stall_first_wr_cycle", wr_cycles[wr0], drop - 5);
      check_eq("stall_second_wr_cycle", wr_cycles[wr0+1], drop + 1);
    end
    check_tx("stall");

    // send_tick and a waiting byte in the same idle cycle: replay first, then pop.
    wr0 = wr_cycles.size();
    rd0 = rd_cycles.size();
    queue_send_exp();
    push_rx(8'h78);
    send_tick = 1'b1;
    tick();
    send_tick = 1'b0;
    settle("prio");
    check_eq("prio_pops", rd_cycles.size() - rd0, 1);
    if (rd_cycles.size() > rd0 && wr_cycles.size() >= wr0 + 2)
      check_eq("prio_pop_after_send", rd_cycles[rd0] > wr_cycles[wr0+1], 1);
    check_state("prio");
    check_tx("prio");

    // Randomized mix of receive bursts and stalled replays.
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        int k = $urandom_range(1, 3);
        for (int j = 0; j < k; j++) begin
          push_rx(8'($urandom));
          repeat ($urandom_range(0, 4)) tick();
        end
        settle("rand_rx");
      end else begin
        int n = 0;
        queue_send_exp();
        send_tick = 1'b1;
        tick();
        send_tick = 1'b0;
        while (busy && n < 200) begin
          tx_full = ($urandom_range(0, 2) == 0);
          tick();
          n++;
        end
        tx_full = 1'b0;
        settle("rand_send");
      end
      check_state("rand");
      check_tx("rand");
    end

    // Reset in the middle of a replay, while the first write strobe is up.
    send_tick = 1'b1;
    tick();
    send_tick = 1'b0;
    tick();
    check_eq("pre_reset_wr", wr_uart, 1);
    reset = 1'b1;
    #1;
    check_eq("midrst_wr_uart", wr_uart, 0);
    check_eq("midrst_rd_uart", rd_uart, 0);
    check_eq("midrst_w_data", w_data, 0);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_words", words, 0);
    check_eq("midrst_count", count, 0);
    repeat (2) tick();
    reset = 1'b0;
    hist.delete();
    exp_tx.delete();
    rd0 = rd_cycles.size();
    repeat (6) tick();
    check_eq("postrst_no_wr", tx_got.size(), 0);
    check_eq("postrst_no_rd", rd_cycles.size() - rd0, 0);
    check_eq("postrst_busy", busy, 0);

    // Resume after reset with a fresh byte.
    push_rx(8'hA5);
    settle("resume");
    check_eq("resume_pops", rd_cycles.size() - rd0, 1);
`ifdef UART_BUF_ECHO_EN
    if (rd_cycles.size() > rd0 && wr_cycles.size() > 0)
      check_eq("echo_in_hold", wr_cycles[$], rd_cycles[rd0] + 1);
`endif
    check_state("resume");
    check_tx("resume");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_byte_shiftbuf.md
UART_BYTE_SHIFTBUF -- requirements
Module: uart_byte_shiftbuf

Interface
REQ-001 SHALL have parameter NBYTES, default 2, meaning the number of bytes held in history (legal range 1..16).
REQ-002 SHALL have parameter WIDTH, default 8, meaning the width of each UART data word.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all logic is on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port rx_empty, input, 1 bit: UART receive FIFO is empty.
REQ-006 SHALL have port r_data, input, WIDTH bits: UART receive FIFO head (show-ahead, valid while rx_empty=0).
REQ-007 SHALL have port rd_uart, output, 1 bit: one-cycle pop strobe to the receive FIFO.
REQ-008 SHALL have port tx_full, input, 1 bit: UART transmit FIFO is full.
REQ-009 SHALL have port w_data, output, WIDTH bits: byte presented to the transmit FIFO.
REQ-010 SHALL have port wr_uart, output, 1 bit: one-cycle push strobe to the transmit FIFO.
REQ-011 SHALL have port send_tick, input, 1 bit: single-cycle request to replay the buffer (already debounced).
REQ-012 SHALL have port words, output, NBYTES*WIDTH bits: history; byte 0 (LSBs) is the newest.
REQ-013 SHALL have port count, output, $clog2(NBYTES+1) bits: number of valid bytes, saturating at NBYTES.
REQ-014 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, POP, HOLD and SEND.
REQ-016 IDLE SHALL go to SEND when send_tick=1, else to POP when rx_empty=0, else remain in IDLE; send_tick SHALL win when both conditions hold in the same cycle.
REQ-017 POP SHALL assert rd_uart for exactly one cycle, shift words left by WIDTH with r_data entering byte 0 and the oldest byte discarded, increment count saturating at NBYTES, and go to HOLD.
REQ-018 HOLD SHALL last exactly one cycle, so the FIFO empty flag settles, then go to IDLE; the minimum spacing between two pops is therefore 3 cycles.
REQ-019 On entry to SEND, the index SHALL load count-1; if count=0, the FSM SHALL return to IDLE without any write.
REQ-020 In SEND, when tx_full=0 the block SHALL drive w_data=words[index], pulse wr_uart for one cycle and decrement index, so transmission is oldest byte first.
REQ-021 In SEND, when tx_full=1 the block SHALL hold wr_uart=0 and keep index unchanged (stall with no loss).
REQ-022 After the byte at index 0 is written, the FSM SHALL return to IDLE; words and count SHALL be unchanged by SEND.
REQ-023 send_tick SHALL be ignored outside IDLE, and rx_empty=0 SHALL not pop while in SEND; received bytes wait in the FIFO.
REQ-024 rd_uart and wr_uart SHALL be registered outputs, and w_data SHALL be stable during any cycle in which wr_uart=1.

Reset
REQ-025 Reset SHALL asynchronously force state=IDLE, words=0, count=0, index=0, rd_uart=0, wr_uart=0, w_data=0 and busy=0.
REQ-026 Reset asserted mid-SEND or mid-POP SHALL abort the operation with no further strobes; strobes SHALL resume only after reset deasserts and a new condition occurs.

Configuration
REQ-027 When macro UART_BUF_ECHO_EN is defined, HOLD SHALL also push the just-popped byte to the transmit FIFO (wr_uart=1, w_data=that byte) if tx_full=0; if tx_full=1, the echo SHALL be dropped silently.
REQ-028 Without UART_BUF_ECHO_EN, wr_uart SHALL assert only in SEND, and the echo logic SHALL not be synthesised.

Structure
REQ-029 The state enum and default WIDTH constant SHALL reside in shared package uart_buf_pkg.
REQ-030 The block SHALL be a single module with no sub-module; it connects to the existing uart and debounce instances at the top level.

Verification
REQ-031 Push 0x12, 0x34, 0x56 into the rx model with NBYTES=2 -> words=0x3456, count=2, exactly 3 rd_uart pulses each separated by at least 3 cycles.
REQ-032 With buffer 0x3456, count=2, tx_full=0, pulse send_tick -> wr_uart twice in consecutive SEND cycles carrying 0x34 then 0x56, busy falls after that, words unchanged.
REQ-033 Hold tx_full=1 for 5 cycles after the first SEND write -> second write (0x56) occurs in the cycle after tx_full drops, and no byte is lost or duplicated.
REQ-034 Apply send_tick and rx_empty=0 in the same IDLE cycle -> SEND executes first, then the pending byte is popped after return to IDLE.
REQ-035 Pulse send_tick with count=0 -> no wr_uart, and busy is high for exactly 1 cycle.
REQ-036 Assert reset during SEND after one write -> outputs go to reset values immediately; with UART_BUF_ECHO_EN defined, popping 0xA5 -> one wr_uart carrying 0xA5 in the HOLD cycle.
